// File: rtl/dino_pkg.sv
// Shared definitions for the dino player controller and the sprite renderer.
//   - dino_state_t : player state encoding
//   - YPOS_W/VEL_W : signed widths of height and velocity
//   - GROUND_Y     : height value meaning "standing on the ground"
package dino_pkg;

    localparam int YPOS_W = 6;
    localparam int VEL_W  = 6;

    localparam logic [YPOS_W-1:0] GROUND_Y = '0;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_DUCK   = 2'd1,
        ST_RISE   = 2'd2,
        ST_FALL   = 2'd3
    } dino_state_t;

    // Jump is only accepted from a grounded state.
    function automatic logic is_grounded(input dino_state_t s);
        return (s == ST_GROUND) || (s == ST_DUCK);
    endfunction

endpackage

// File: rtl/dino_anim_div.sv
// Run-cycle animation divider: a modulo-ANIM_DIV tick counter that toggles
// o_frame each time it wraps. Counter and frame hold whenever i_en is low.
//   clk, rst_n : clock, async active-low reset
//   i_tick     : one-clk advance strobe
//   i_en       : advance enable (low = hold)
//   o_frame    : toggling frame select
module dino_anim_div #(
    parameter int ANIM_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_en,
    output logic o_frame
);

    localparam int CW = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else if (i_tick && i_en) begin
            if (r_cnt == CW'(ANIM_DIV - 1)) begin
                r_cnt   <= '0;
                r_frame <= ~r_frame;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_frame = r_frame;

endmodule

// File: rtl/dino_player_ctrl.sv
// Dino player physics/state controller. Integrates jump velocity and gravity
// once per frame tick and produces the sprite's signed height above ground.
//   clk, rst_n     : pixel clock, async active-low reset
//   i_frame_tick   : one-clk pulse per frame (vertical blank)
//   i_jump, i_duck : synchronised button levels
//   i_halt         : freeze all physics (game over)
//   o_ypos         : signed height, 0 = ground
//   o_airborne     : state is RISE or FALL
//   o_ducking      : state is DUCK
//   o_anim_frame   : run-cycle frame select
module dino_player_ctrl
    import dino_pkg::*;
#(
    parameter int JUMP_VEL     = 7,
    parameter int GRAVITY      = 1,
    parameter int FAST_GRAVITY = 2,
    parameter int TERM_VEL     = -8,
    parameter int MAX_HEIGHT   = 31,
    parameter int ANIM_DIV     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_frame_tick,
    input  logic              i_jump,
    input  logic              i_duck,
    input  logic              i_halt,
    output logic [YPOS_W-1:0] o_ypos,
    output logic              o_airborne,
    output logic              o_ducking,
    output logic              o_anim_frame
);

    // 8-bit signed working copies; sums never wrap at this width.
    localparam logic signed [7:0] JV8 = 8'(JUMP_VEL);
    localparam logic signed [7:0] G8  = 8'(GRAVITY);
    localparam logic signed [7:0] FG8 = 8'(FAST_GRAVITY);
    localparam logic signed [7:0] TV8 = 8'(TERM_VEL);
    localparam logic signed [7:0] MH8 = 8'(MAX_HEIGHT);

    dino_state_t       r_state, w_state_nxt;
    logic [YPOS_W-1:0] r_ypos, w_ypos_nxt;
    logic [VEL_W-1:0]  r_vel, w_vel_nxt;
    logic              r_jump_prev, r_jump_pending;

    logic              w_tick_act, w_jump_edge, w_jump_req;
    logic signed [7:0] w_grav, w_vel_dec, w_vel_clamp, w_ypos_sum;

    assign w_tick_act  = i_frame_tick & ~i_halt;
    assign w_jump_edge = i_jump & ~r_jump_prev;
    // An edge in the tick's own clk is honoured on that tick.
    assign w_jump_req  = r_jump_pending | w_jump_edge;

    // Height integrates the already-decremented velocity; the stored velocity
    // is saturated at terminal, but the step taken this tick is not.
    assign w_grav      = i_duck ? FG8 : G8;
    assign w_vel_dec   = {{(8-VEL_W){r_vel[VEL_W-1]}}, r_vel} - w_grav;
    assign w_vel_clamp = (w_vel_dec < TV8) ? TV8 : w_vel_dec;
    assign w_ypos_sum  = {{(8-YPOS_W){r_ypos[YPOS_W-1]}}, r_ypos} + w_vel_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_GROUND;
            r_ypos         <= GROUND_Y;
            r_vel          <= '0;
            r_jump_prev    <= 1'b0;
            r_jump_pending <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ypos      <= w_ypos_nxt;
            r_vel       <= w_vel_nxt;
            r_jump_prev <= i_jump;
            // Every live tick either consumes the request or discards it
            // (airborne); halted ticks leave it pending.
            if (w_tick_act)
                r_jump_pending <= 1'b0;
            else if (w_jump_edge)
                r_jump_pending <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ypos_nxt  = r_ypos;
        w_vel_nxt   = r_vel;
        if (w_tick_act) begin
            case (r_state)
                ST_GROUND, ST_DUCK: begin
                    if (w_jump_req) begin
                        w_vel_nxt   = JV8[VEL_W-1:0];
                        w_ypos_nxt  = JV8[YPOS_W-1:0];
                        w_state_nxt = ST_RISE;
                    end else begin
                        w_state_nxt = i_duck ? ST_DUCK : ST_GROUND;
                    end
                end
                ST_RISE, ST_FALL: begin
                    if (w_ypos_sum <= 8'sd0) begin
                        w_ypos_nxt  = GROUND_Y;
                        w_vel_nxt   = '0;
                        w_state_nxt = i_duck ? ST_DUCK : ST_GROUND;
                    end else begin
                        w_ypos_nxt  = (w_ypos_sum > MH8) ? MH8[YPOS_W-1:0]
                                                         : w_ypos_sum[YPOS_W-1:0];
                        w_vel_nxt   = w_vel_clamp[VEL_W-1:0];
                        w_state_nxt = (w_vel_clamp > 8'sd0) ? ST_RISE : ST_FALL;
                    end
                end
                default: w_state_nxt = ST_GROUND;
            endcase
        end
    end

    dino_anim_div #(.ANIM_DIV(ANIM_DIV)) u_anim (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (w_tick_act),
        .i_en    (r_state == ST_GROUND),
        .o_frame (o_anim_frame)
    );

    assign o_ypos     = r_ypos;
    assign o_airborne = (r_state == ST_RISE) || (r_state == ST_FALL);
    assign o_ducking  = (r_state == ST_DUCK);

endmodule

// File: tb/tb_dino_player_ctrl.sv
module tb_dino_player_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_frame_tick = 1'b0;
    logic       i_jump = 1'b0;
    logic       i_duck = 1'b0;
    logic       i_halt = 1'b0;
    logic [5:0] o_ypos;
    logic       o_airborne, o_ducking, o_anim_frame;

    int n_run  = 0;
    int n_fail = 0;

    dino_player_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame_tick (i_frame_tick),
        .i_jump       (i_jump),
        .i_duck       (i_duck),
        .i_halt       (i_halt),
        .o_ypos       (o_ypos),
        .o_airborne   (o_airborne),
        .o_ducking    (o_ducking),
        .o_anim_frame (o_anim_frame)
    );

    always #5 clk = ~clk;

    // One frame tick; returns at a negedge with the tick's results visible.
    task automatic tick();
        @(negedge clk) i_frame_tick = 1'b1;
        @(negedge clk) i_frame_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_jump();
        @(negedge clk) i_jump = 1'b1;
        @(negedge clk) i_jump = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int exp_anim [4] = '{0, 0, 0, 1};
        repeat (2) @(negedge clk);
        n_run++;
        if ({o_ypos, o_airborne, o_ducking, o_anim_frame} !== 9'd0) begin
            $display("FAIL reset_outputs: got ypos=%0d air=%b duck=%b anim=%b want all 0",
                     o_ypos, o_airborne, o_ducking, o_anim_frame);
            n_fail++;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_run++;
            if (o_ypos !== 6'd0 || o_airborne !== 1'b0 || o_anim_frame !== exp_anim[t][0]) begin
                $display("FAIL idle_tick%0d: got ypos=%0d air=%b anim=%b want 0 0 %0d",
                         t + 1, o_ypos, o_airborne, o_anim_frame, exp_anim[t]);
                n_fail++;
            end
        end
    endtask

    task automatic test_halt_ground();
        do_reset();
        i_halt = 1'b1;
        repeat (4) tick();
        n_run++;
        if (o_anim_frame !== 1'b0) begin
            $display("FAIL halt_anim_hold: got %b want 0", o_anim_frame);
            n_fail++;
        end
        i_halt = 1'b0;
        repeat (3) tick();
        n_run++;
        if (o_anim_frame !== 1'b0) begin
            $display("FAIL anim_after_halt3: got %b want 0", o_anim_frame);
            n_fail++;
        end
        tick();
        n_run++;
        if (o_anim_frame !== 1'b1) begin
            $display("FAIL anim_after_halt4: got %b want 1", o_anim_frame);
            n_fail++;
        end
    endtask

    task automatic test_jump();
        int exp_y [15] = '{7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};
        pulse_jump();
        for (int t = 0; t < 15; t++) begin
            tick();
            n_run++;
            if (o_ypos !== exp_y[t][5:0] || o_airborne !== (t < 14)) begin
                $display("FAIL jump_tick%0d: got ypos=%0d air=%b want ypos=%0d air=%b",
                         t + 1, o_ypos, o_airborne, exp_y[t], (t < 14));
                n_fail++;
            end
        end
    endtask

    task automatic test_duck_fall();
        int exp_y [13] = '{7, 13, 18, 22, 25, 27, 28, 27, 24, 19, 12, 3, 0};
        pulse_jump();
        for (int t = 0; t < 13; t++) begin
            i_duck = (t >= 7);
            tick();
            n_run++;
            if (o_ypos !== exp_y[t][5:0]) begin
                $display("FAIL duck_fall_tick%0d: got ypos=%0d want %0d", t + 1, o_ypos, exp_y[t]);
                n_fail++;
            end
        end
        n_run++;
        if (o_ducking !== 1'b1 || o_airborne !== 1'b0) begin
            $display("FAIL duck_landing: got duck=%b air=%b want 1 0", o_ducking, o_airborne);
            n_fail++;
        end
    endtask

    task automatic test_jump_from_duck();
        // i_duck still held from the previous scenario; edge and tick share a clk.
        @(negedge clk) begin
            i_jump = 1'b1;
            i_frame_tick = 1'b1;
        end
        @(negedge clk) begin
            i_frame_tick = 1'b0;
            i_jump = 1'b0;
            i_duck = 1'b0;
        end
        @(negedge clk);
        n_run++;
        if (o_ypos !== 6'd7 || o_ducking !== 1'b0 || o_airborne !== 1'b1) begin
            $display("FAIL duck_jump_same_clk: got ypos=%0d duck=%b air=%b want 7 0 1",
                     o_ypos, o_ducking, o_airborne);
            n_fail++;
        end
        repeat (14) tick();
        n_run++;
        if (o_ypos !== 6'd0 || o_airborne !== 1'b0 || o_ducking !== 1'b0) begin
            $display("FAIL duck_jump_land: got ypos=%0d air=%b duck=%b want 0 0 0",
                     o_ypos, o_airborne, o_ducking);
            n_fail++;
        end
    endtask

    task automatic test_halt_air();
        int exp_y [10] = '{25, 27, 28, 28, 27, 25, 22, 18, 13, 7};
        pulse_jump();
        repeat (4) tick();
        n_run++;
        if (o_ypos !== 6'd22) begin
            $display("FAIL halt_setup: got ypos=%0d want 22", o_ypos);
            n_fail++;
        end
        i_halt = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (t == 2) pulse_jump();
            tick();
            n_run++;
            if (o_ypos !== 6'd22 || o_airborne !== 1'b1 || o_anim_frame !== 1'b1) begin
                $display("FAIL halt_hold%0d: got ypos=%0d air=%b anim=%b want 22 1 1",
                         t + 1, o_ypos, o_airborne, o_anim_frame);
                n_fail++;
            end
        end
        i_halt = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            n_run++;
            if (o_ypos !== exp_y[t][5:0]) begin
                $display("FAIL halt_resume%0d: got ypos=%0d want %0d", t + 1, o_ypos, exp_y[t]);
                n_fail++;
            end
        end
        tick();
        n_run++;
        if (o_ypos !== 6'd0 || o_airborne !== 1'b0) begin
            $display("FAIL halt_land: got ypos=%0d air=%b want 0 0", o_ypos, o_airborne);
            n_fail++;
        end
        // Landing must not re-launch from the edge seen during the halt.
        tick();
        n_run++;
        if (o_ypos !== 6'd0 || o_airborne !== 1'b0) begin
            $display("FAIL halt_stale_jump: got ypos=%0d air=%b want 0 0", o_ypos, o_airborne);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_jump();
        pulse_jump();
        repeat (3) tick();
        n_run++;
        if (o_ypos !== 6'd18) begin
            $display("FAIL rst_setup: got ypos=%0d want 18", o_ypos);
            n_fail++;
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({o_ypos, o_airborne, o_ducking, o_anim_frame} !== 9'd0) begin
            $display("FAIL async_reset: got ypos=%0d air=%b duck=%b anim=%b want all 0",
                     o_ypos, o_airborne, o_ducking, o_anim_frame);
            n_fail++;
        end
        @(negedge clk) rst_n = 1'b1;
        pulse_jump();
        tick();
        n_run++;
        if (o_ypos !== 6'd7 || o_airborne !== 1'b1) begin
            $display("FAIL post_reset_jump1: got ypos=%0d air=%b want 7 1", o_ypos, o_airborne);
            n_fail++;
        end
        tick();
        n_run++;
        if (o_ypos !== 6'd13) begin
            $display("FAIL post_reset_jump2: got ypos=%0d want 13", o_ypos);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_halt_ground();
        test_jump();
        test_duck_fall();
        test_jump_from_duck();
        test_halt_air();
        test_reset_mid_jump();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
